// File: rtl/seg7_pkg.sv
// Shared code points, segment bit positions and the display-code type for the
// seven-segment scan driver.
package seg7_pkg;

  typedef logic [4:0] seg7_code_t;

  localparam seg7_code_t SEG7_DASH    = 5'h0A;
  localparam seg7_code_t SEG7_HEX_A   = 5'h0B;
  localparam seg7_code_t SEG7_BLANK   = 5'h14;
  localparam seg7_code_t SEG7_DP_ONLY = 5'h15;

  // Segment pin order, bit7..bit0 = {DP,F,G,A,B,D,C,E}
  localparam int SEG_DP = 7;
  localparam int SEG_F  = 6;
  localparam int SEG_G  = 5;
  localparam int SEG_A  = 4;
  localparam int SEG_B  = 3;
  localparam int SEG_D  = 2;
  localparam int SEG_C  = 1;
  localparam int SEG_E  = 0;

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational display-code to active-high segment pattern lookup.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  seg7_code_t  code,
  output logic [7:0]  pattern
);

  always_comb begin
    pattern = 8'h00;
    case (code)
      5'h00:        pattern = 8'h5F;
      5'h01:        pattern = 8'h0A;
      5'h02:        pattern = 8'h3D;
      5'h03:        pattern = 8'h3E;
      5'h04:        pattern = 8'h6A;
      5'h05:        pattern = 8'h76;
      5'h06:        pattern = 8'h77;
      5'h07:        pattern = 8'h1A;
      5'h08:        pattern = 8'h7F;
      5'h09:        pattern = 8'h7E;
      SEG7_DASH:    pattern[SEG_G] = 1'b1;
      SEG7_HEX_A:   pattern = 8'h7B;
      5'h0C:        pattern = 8'h67;
      5'h0D:        pattern = 8'h25;
      5'h0E:        pattern = 8'h2F;
      5'h0F:        pattern = 8'h75;
      5'h10:        pattern = 8'h71;
      SEG7_BLANK:   pattern = 8'h00;
      SEG7_DP_ONLY: pattern[SEG_DP] = 1'b1;
      default:      pattern = 8'h00;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with per-frame snapshot and guard blanking.
// Optional: define SEG7_LEAD_ZERO_BLANK_EN to blank leading zeros when the snapshot is captured.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int GUARD          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [5*N_DIGITS-1:0] codes,
  input  logic [N_DIGITS-1:0]   dp,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   dig,
  output logic                  frame
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]          SEG_OFF  = {8{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{DIG_ACTIVE_LOW}};

  logic [DIV_W-1:0]    div_cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  seg7_code_t          snap_codes_reg [N_DIGITS];
  logic [N_DIGITS-1:0] snap_dp_reg;
  logic [7:0]          seg_reg;
  logic [N_DIGITS-1:0] dig_reg;
  logic                frame_reg;

  seg7_code_t          cap_codes [N_DIGITS];
  seg7_code_t          cur_code;
  logic                cur_dp;
  logic [7:0]          glyph;
  logic [7:0]          seg_lit;
  logic [N_DIGITS-1:0] dig_lit;
  logic                in_guard;

  genvar gi;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  // Walk down from the MSD; the leading run of zero codes without dp is blanked, digit 0 excepted.
  always_comb begin
    logic run;
    run       = 1'b1;
    cap_codes = '{default: SEG7_BLANK};
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      cap_codes[k] = codes[5*k +: 5];
      run = run & (codes[5*k +: 5] == 5'h00) & ~dp[k];
      if (run && (k != 0)) cap_codes[k] = SEG7_BLANK;
    end
  end
`else
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_cap
      assign cap_codes[gi] = codes[5*gi +: 5];
    end
  endgenerate
`endif

  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_onehot
      assign dig_lit[gi] = (idx_reg == IDX_W'(gi));
    end

    if (N_DIGITS == 1) begin : g_one
      assign cur_code = snap_codes_reg[0];
      assign cur_dp   = snap_dp_reg[0];
    end else begin : g_many
      assign cur_code = snap_codes_reg[idx_reg];
      assign cur_dp   = snap_dp_reg[idx_reg];
    end

    if (GUARD == 0) begin : g_noguard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (div_cnt_reg < DIV_W'(GUARD));
    end
  endgenerate

  seg7_glyph_rom u_rom (
    .code    (cur_code),
    .pattern (glyph)
  );

  assign seg_lit = glyph | {cur_dp, 7'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg    <= '0;
      idx_reg        <= '0;
      snap_codes_reg <= '{default: SEG7_BLANK};
      snap_dp_reg    <= '0;
      seg_reg        <= SEG_OFF;
      dig_reg        <= DIG_OFF;
      frame_reg      <= 1'b0;
    end else if (!en) begin
      // Disabled: keep tracking the inputs so the first frame after enable is current.
      div_cnt_reg    <= '0;
      idx_reg        <= '0;
      snap_codes_reg <= cap_codes;
      snap_dp_reg    <= dp;
      seg_reg        <= SEG_OFF;
      dig_reg        <= DIG_OFF;
      frame_reg      <= 1'b0;
    end else begin
      frame_reg <= 1'b0;
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_reg <= '0;
        if (idx_reg == IDX_LAST) begin
          idx_reg        <= '0;
          snap_codes_reg <= cap_codes;
          snap_dp_reg    <= dp;
          frame_reg      <= 1'b1;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end

      if (in_guard) begin
        seg_reg <= SEG_OFF;
        dig_reg <= DIG_OFF;
      end else begin
        seg_reg <= seg_lit ^ SEG_OFF;
        dig_reg <= dig_lit ^ DIG_OFF;
      end
    end
  end

  assign seg   = seg_reg;
  assign dig   = dig_reg;
  assign frame = frame_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed vector table, hand sequences and a
// randomized run checked against a frame-position reference model (two configurations).
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [19:0] codes;
  logic [3:0]  dp;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame;
  logic [7:0]  seg1;
  logic [0:0]  dig1;
  logic        frame1;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .en(en), .codes(codes), .dp(dp),
    .seg(seg), .dig(dig), .frame(frame)
  );

  seg7_scan_driver #(.N_DIGITS(1), .SCAN_DIV(4), .GUARD(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .codes(codes[4:0]), .dp(dp[0:0]),
    .seg(seg1), .dig(dig1), .frame(frame1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: p = position within the frame, plain arithmetic gives slot and offset.
  int         mn  [2] = '{4, 1};
  int         msd [2] = '{8, 4};
  int         mg  [2] = '{2, 0};
  int         p   [2];
  logic [4:0] msnap [2][4];
  logic       mdp   [2][4];
  logic [7:0] eseg [2];
  logic [3:0] edig [2];
  logic       efr  [2];

  function automatic logic [7:0] ref_glyph(input logic [4:0] c);
    case (c)
      5'h00: return 8'h5F;  5'h01: return 8'h0A;  5'h02: return 8'h3D;
      5'h03: return 8'h3E;  5'h04: return 8'h6A;  5'h05: return 8'h76;
      5'h06: return 8'h77;  5'h07: return 8'h1A;  5'h08: return 8'h7F;
      5'h09: return 8'h7E;  5'h0A: return 8'h20;  5'h0B: return 8'h7B;
      5'h0C: return 8'h67;  5'h0D: return 8'h25;  5'h0E: return 8'h2F;
      5'h0F: return 8'h75;  5'h10: return 8'h71;  5'h15: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  task automatic capture(input int m);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    bit run;
    run = 1'b1;
`endif
    for (int k = mn[m] - 1; k >= 0; k--) begin
      logic [4:0] c;
      c = codes[5*k +: 5];
      msnap[m][k] = c;
      mdp[m][k]   = dp[k];
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      run = run && (c == 5'h00) && !dp[k];
      if (run && k > 0) msnap[m][k] = 5'h14;
`endif
    end
  endtask

  task automatic model_step(input int m);
    int slot;
    int pos;
    if (rst) begin
      eseg[m] = 8'h00; edig[m] = 4'h0; efr[m] = 1'b0; p[m] = 0;
      for (int k = 0; k < 4; k++) begin
        msnap[m][k] = 5'h14; mdp[m][k] = 1'b0;
      end
    end else if (!en) begin
      eseg[m] = 8'h00; edig[m] = 4'h0; efr[m] = 1'b0; p[m] = 0;
      capture(m);
    end else begin
      slot = p[m] / msd[m];
      pos  = p[m] % msd[m];
      if (pos >= mg[m]) begin
        edig[m] = 4'(1 << slot);
        eseg[m] = ref_glyph(msnap[m][slot]) | (mdp[m][slot] ? 8'h80 : 8'h00);
      end else begin
        edig[m] = 4'h0;
        eseg[m] = 8'h00;
      end
      efr[m] = (p[m] == mn[m] * msd[m] - 1);
      if (efr[m]) capture(m);
      p[m] = (p[m] + 1) % (mn[m] * msd[m]);
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [3:0] xd;
    logic       xd1;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    xd  = ~edig[0];
    xd1 = ~edig[1][0];
    cmp("seg", seg, eseg[0]);
    cmp("dig", dig, xd);
    cmp("frame", frame, efr[0]);
    cmp("seg_n1", seg1, eseg[1]);
    cmp("dig_n1", dig1, xd1);
    cmp("frame_n1", frame1, efr[1]);
  endtask

  task automatic wait_frame(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      step();
      if (frame) break;
    end
    if (i == budget) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: got no pulse, expected one within %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic [19:0] codes;
    logic [3:0]  dp;
    logic [31:0] exp;   // expected seg per digit, digit k at [8k+7:8k]
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lit;
    int lit1;
    logic [3:0] xdig;

    vecs[0] = '{codes: {5'h03, 5'h02, 5'h01, 5'h00}, dp: 4'b0000, exp: 32'h3E3D0A5F};
    vecs[1] = '{codes: {5'h10, 5'h1F, 5'h15, 5'h0B}, dp: 4'b0110, exp: 32'h7180807B};
    vecs[2] = '{codes: {5'h08, 5'h08, 5'h08, 5'h08}, dp: 4'b0000, exp: 32'h7F7F7F7F};
    vecs[4] = '{codes: {5'h0A, 5'h0F, 5'h0D, 5'h0C}, dp: 4'b0001, exp: 32'h207525E7};
    vecs[5] = '{codes: {5'h14, 5'h11, 5'h09, 5'h07}, dp: 4'b1000, exp: 32'h80007E1A};
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    vecs[3] = '{codes: {5'h00, 5'h00, 5'h04, 5'h00}, dp: 4'b0000, exp: 32'h00006A5F};
    vecs[6] = '{codes: {5'h00, 5'h00, 5'h00, 5'h00}, dp: 4'b0100, exp: 32'h00DF5F5F};
    vecs[7] = '{codes: {5'h00, 5'h00, 5'h00, 5'h00}, dp: 4'b0000, exp: 32'h0000005F};
`else
    vecs[3] = '{codes: {5'h00, 5'h00, 5'h04, 5'h00}, dp: 4'b0000, exp: 32'h5F5F6A5F};
    vecs[6] = '{codes: {5'h00, 5'h00, 5'h00, 5'h00}, dp: 4'b0100, exp: 32'h5FDF5F5F};
    vecs[7] = '{codes: {5'h00, 5'h00, 5'h00, 5'h00}, dp: 4'b0000, exp: 32'h5F5F5F5F};
`endif

    // Reset held 3 cycles with en high: rst wins, everything off.
    rst = 1'b1; en = 1'b1; codes = vecs[0].codes; dp = 4'b0;
    repeat (3) step();
    cmp("rst_seg", seg, 8'h00);
    cmp("rst_dig", dig, 4'hF);
    cmp("rst_frame", frame, 1'b0);
    rst = 1'b0;
    step();
    cmp("post_rst_seg", seg, 8'h00);
    cmp("post_rst_dig", dig, 4'hF);

    // First frame shows the blank reset snapshot; the pulse captures the codes.
    wait_frame(40);
    repeat (3) step();
    cmp("slot0_seg", seg, 8'h5F);
    cmp("slot0_dig", dig, 4'b1110);
    lit = 1; lit1 = 3;  // the three steps above: dut lit once, dut1 lit every cycle
    for (int j = 4; j <= 32; j++) begin
      step();
      if (dig != 4'hF) lit++;
      if (dig1 == 1'b0) lit1++;
    end
    cmp("frame_period", frame, 1'b1);
    cmp("guard_lit_count", lit, 24);
    cmp("noguard_lit_count", lit1, 32);

    // Snapshot: change inputs mid-frame; old glyphs finish, new ones appear after the pulse.
    for (int j = 1; j <= 32; j++) begin
      if (j == 10) codes = vecs[2].codes;
      step();
      if (j == 21) cmp("snap_hold_d2", seg, 8'h3D);
      if (j == 29) cmp("snap_hold_d3", seg, 8'h3E);
    end
    cmp("snap_frame", frame, 1'b1);
    repeat (5) step();
    cmp("snap_new", seg, 8'h7F);

    // Table of glyph vectors: load while disabled, then scan one frame.
    foreach (vecs[i]) begin
      rst = 1'b1; step();
      rst = 1'b0; en = 1'b0; codes = vecs[i].codes; dp = vecs[i].dp;
      step(); step();
      en = 1'b1;
      for (int c = 1; c <= 32; c++) begin
        step();
        if (c % 8 == 5) begin
          xdig = ~(4'b0001 << (c / 8));
          cmp($sformatf("vec%0d_seg", i), seg, vecs[i].exp[8*(c/8) +: 8]);
          cmp($sformatf("vec%0d_dig", i), dig, xdig);
        end
      end
      cmp($sformatf("vec%0d_frame", i), frame, 1'b1);
    end

    // Randomized run against the model, biased toward zeros and enabled operation.
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 4; k++)
          codes[5*k +: 5] = ($urandom_range(0, 2) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
        dp = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
